// File: rtl/fifo_rd_pkg.sv
// Shared types and defaults for the FIFO read-side streaming stage.
package fifo_rd_pkg;

  localparam int DEF_FIFO_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_e;

  typedef struct packed {
    logic [DEF_FIFO_WIDTH-1:0] data;
    logic                      last;
  } buf_entry_t;

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry output buffer: ring of two slots with head/tail pointers and occupancy.
module fifo_rd_skid
  import fifo_rd_pkg::*;
#(
  parameter int W = DEF_FIFO_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         push_last,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic         head_last,
  output logic [1:0]   occ
);

  logic [W-1:0] data_q [2];
  logic [1:0]   last_q;
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   occ_q;

  // Slot storage, pointers and occupancy; push and pop together leave occupancy unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q[0] <= '0;
      data_q[1] <= '0;
      last_q    <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      occ_q     <= 2'd0;
    end else begin
      if (push) begin
        data_q[wr_ptr] <= push_data;
        last_q[wr_ptr] <= push_last;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign head_data = data_q[rd_ptr];
  assign head_last = last_q[rd_ptr];
  assign occ       = occ_q;

  // The upstream credit check must never let a word arrive while both slots are full.
  assert property (@(posedge clk) disable iff (!rst_n) !(push && (occ_q == 2'd2)));

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains a synchronous FIFO onto a valid/ready stream with burst tagging and an underflow counter.
module fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int BURST_LEN  = 4,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  output logic                  fifo_rd_en,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  busy,
  output logic [CNT_W-1:0]      underflow_cnt
);

  localparam logic [7:0] LAST_POS = 8'(BURST_LEN - 1);

  state_e     state;
  logic       inflight;
  logic [7:0] burst_cnt;
  logic [1:0] occ;
  logic       pop;
  logic       push_last;
  logic [2:0] credit_used;
  logic [2:0] credit_lim;

  // A read is allowed only if the word it returns is guaranteed a free buffer slot.
  assign pop         = m_valid && m_ready;
  assign credit_used = {1'b0, occ} + {2'b00, inflight};
  assign credit_lim  = 3'd2 + {2'b00, pop};
  assign fifo_rd_en  = (state == RUN) && enable && !fifo_empty && (credit_used < credit_lim);

  assign push_last = (burst_cnt == LAST_POS);
  assign m_valid   = (occ != 2'd0);
  assign busy      = (state != IDLE) || m_valid;

  fifo_rd_skid #(
    .W(FIFO_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_data (fifo_data_out),
    .push_last (push_last),
    .pop       (pop),
    .head_data (m_data),
    .head_last (m_last),
    .occ       (occ)
  );

  // Marks the cycle where the FIFO's registered output holds the word we requested.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
    end
  end

  // Burst position advances per captured word and survives enable drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt <= 8'd0;
    end else if (inflight) begin
      burst_cnt <= push_last ? 8'd0 : burst_cnt + 8'd1;
    end
  end

  // Control FSM: STOP waits for the last in-flight word and the buffer to drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (enable) state <= RUN;
        RUN:  if (!enable && !inflight) state <= STOP;
        STOP: begin
          if (enable) begin
            state <= RUN;
          end else if (occ == 2'd0) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Saturating debug count of FIFO underflow pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underflow_cnt <= '0;
    end else if (fifo_underflow && (underflow_cnt != '1)) begin
      underflow_cnt <= underflow_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench for fifo_rd_stream with a behavioural FIFO and scoreboard.
module tb_fifo_rd_stream;
  import fifo_rd_pkg::*;

  localparam int BURST_LEN = 4;
  localparam int CNT_W     = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             enable;
  logic [15:0]      fifo_data_out = '0;
  logic             fifo_empty;
  logic             fifo_underflow;
  logic             fifo_rd_en;
  logic [15:0]      m_data;
  logic             m_valid;
  logic             m_ready;
  logic             m_last;
  logic             busy;
  logic [CNT_W-1:0] underflow_cnt;

  int checks   = 0;
  int failures = 0;

  logic [15:0] mem [0:4095];
  int          wr_idx = 0;
  int          rd_idx = 0;

  buf_entry_t  exp_q [$];
  int          burst_pos = 0;
  logic        hold_prev = 1'b0;
  logic [15:0] hold_data = '0;
  int          hs_count = 0;
  logic [15:0] hs_data [0:4095];
  logic        hs_last [0:4095];

  typedef struct {
    logic [15:0] in_word;
    logic [15:0] exp_data;
    logic        exp_last;
  } stream_vec_t;

  typedef struct {
    int pulses;
    int exp_cnt;
  } uf_vec_t;

  stream_vec_t burst_tbl [8];
  uf_vec_t     uf_tbl [3];

  fifo_rd_stream #(
    .FIFO_WIDTH(16),
    .BURST_LEN (BURST_LEN),
    .CNT_W     (CNT_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .fifo_data_out  (fifo_data_out),
    .fifo_empty     (fifo_empty),
    .fifo_underflow (fifo_underflow),
    .fifo_rd_en     (fifo_rd_en),
    .m_data         (m_data),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_last         (m_last),
    .busy           (busy),
    .underflow_cnt  (underflow_cnt)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (rd_idx == wr_idx);

  // Behavioural FIFO: registered read data one cycle after an accepted read.
  always @(posedge clk) begin
    if (fifo_rd_en && (rd_idx != wr_idx)) begin
      fifo_data_out <= mem[rd_idx];
      rd_idx        <= rd_idx + 1;
    end
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic en, input logic rdy);
    @(posedge clk);
    #2;
    enable  = en;
    m_ready = rdy;
  endtask

  task automatic load_word(input logic [15:0] w);
    mem[wr_idx] = w;
    wr_idx++;
  endtask

  task automatic sample_point();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_hs(input int target, input int budget, input string name);
    int n;
    n = 0;
    while ((hs_count < target) && (n < budget)) begin
      sample_point();
      n++;
    end
    check_output(name, 32'(hs_count >= target), 32'd1);
  endtask

  // Scoreboard: words read are expected out in order, tagged by their position in the burst.
  always @(negedge clk) begin
    buf_entry_t e;
    if (!rst_n) begin
      exp_q.delete();
      burst_pos = 0;
      hold_prev = 1'b0;
    end else begin
      check_output("credit", 32'(exp_q.size() <= 2), 32'd1);
      if (hold_prev) begin
        check_output("hold_valid", 32'(m_valid), 32'd1);
        check_output("hold_data", 32'(m_data), 32'(hold_data));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected_word", 32'(m_data), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check_output("stream_data", 32'(m_data), 32'(e.data));
          check_output("stream_last", 32'(m_last), 32'(e.last));
        end
        hs_data[hs_count] = m_data;
        hs_last[hs_count] = m_last;
        hs_count++;
      end
      if (fifo_rd_en) begin
        check_output("rd_when_empty", 32'(fifo_empty), 32'd0);
        e.data = mem[rd_idx];
        e.last = (burst_pos == BURST_LEN - 1);
        exp_q.push_back(e);
        burst_pos = (burst_pos + 1) % BURST_LEN;
      end
      hold_prev = m_valid && !m_ready;
      hold_data = m_data;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence.
  initial begin
    int base;
    int first_rd, last_rd, n_rd;
    int first_v, last_v, n_v;
    int wr_base;

    for (int i = 0; i < 8; i++) begin
      burst_tbl[i].in_word  = 16'(i + 1);
      burst_tbl[i].exp_data = 16'(i + 1);
      burst_tbl[i].exp_last = ((i + 1) % 4 == 0);
    end
    uf_tbl[0] = '{pulses: 3,   exp_cnt: 3};
    uf_tbl[1] = '{pulses: 297, exp_cnt: 255};
    uf_tbl[2] = '{pulses: 1,   exp_cnt: 255};

    rst_n          = 1'b0;
    enable         = 1'b0;
    m_ready        = 1'b0;
    fifo_underflow = 1'b0;
    repeat (3) sample_point();
    check_output("rst_m_valid", 32'(m_valid), 32'd0);
    check_output("rst_m_last", 32'(m_last), 32'd0);
    check_output("rst_m_data", 32'(m_data), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_underflow_cnt", 32'(underflow_cnt), 32'd0);
    check_output("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    $display("[TB] burst of 8 with m_ready high");
    base = hs_count;
    @(posedge clk);
    #2;
    for (int i = 0; i < 8; i++) load_word(burst_tbl[i].in_word);
    enable  = 1'b1;
    m_ready = 1'b1;
    first_rd = -1; last_rd = -1; n_rd = 0;
    first_v  = -1; last_v  = -1; n_v  = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      #1;
      if (fifo_rd_en) begin
        if (first_rd < 0) first_rd = i;
        last_rd = i;
        n_rd++;
      end
      if (m_valid) begin
        if (first_v < 0) first_v = i;
        last_v = i;
        n_v++;
      end
    end
    check_output("rd_count", 32'(n_rd), 32'd8);
    check_output("rd_contiguous", 32'(last_rd - first_rd + 1), 32'd8);
    check_output("valid_count", 32'(n_v), 32'd8);
    check_output("valid_contiguous", 32'(last_v - first_v + 1), 32'd8);
    check_output("rd_to_valid_latency", 32'(first_v - first_rd), 32'd2);
    check_output("burst_hs_count", 32'(hs_count - base), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check_output("tbl_data", 32'(hs_data[base + i]), 32'(burst_tbl[i].exp_data));
      check_output("tbl_last", 32'(hs_last[base + i]), 32'(burst_tbl[i].exp_last));
    end

    $display("[TB] backpressure with m_ready low");
    base = hs_count;
    apply_stimulus(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) load_word(16'h0101 + 16'(i));
    n_rd = 0;
    for (int i = 0; i < 20; i++) begin
      sample_point();
      if (fifo_rd_en) n_rd++;
    end
    check_output("bp_rd_count", 32'(n_rd), 32'd2);
    check_output("bp_m_valid", 32'(m_valid), 32'd1);
    check_output("bp_m_data", 32'(m_data), 32'h0101);
    check_output("bp_rd_en", 32'(fifo_rd_en), 32'd0);
    apply_stimulus(1'b1, 1'b1);
    wait_hs(base + 8, 60, "bp_drain_timeout");
    check_output("bp_first", 32'(hs_data[base]), 32'h0101);
    check_output("bp_final", 32'(hs_data[base + 7]), 32'h0108);

    $display("[TB] toggling m_ready");
    base = hs_count;
    apply_stimulus(1'b1, 1'b1);
    for (int i = 0; i < 6; i++) load_word(16'h0201 + 16'(i));
    for (int c = 0; (c < 60) && (hs_count < base + 6); c++) begin
      @(posedge clk);
      #2 m_ready = !m_ready;
    end
    check_output("toggle_drain", 32'(hs_count >= base + 6), 32'd1);
    for (int i = 0; i < 6; i++) begin
      check_output("toggle_order", 32'(hs_data[base + i]), 32'h0201 + 32'(i));
    end

    $display("[TB] empty FIFO and underflow counting");
    apply_stimulus(1'b1, 1'b1);
    n_rd = 0;
    for (int i = 0; i < 10; i++) begin
      sample_point();
      if (fifo_rd_en) n_rd++;
    end
    check_output("empty_no_read", 32'(n_rd), 32'd0);
    for (int r = 0; r < 3; r++) begin
      @(posedge clk);
      #2 fifo_underflow = 1'b1;
      repeat (uf_tbl[r].pulses) @(posedge clk);
      #2 fifo_underflow = 1'b0;
      sample_point();
      check_output("underflow_cnt", 32'(underflow_cnt), 32'(uf_tbl[r].exp_cnt));
    end

    $display("[TB] enable dropped mid-burst");
    base = hs_count;
    apply_stimulus(1'b1, 1'b1);
    load_word(16'h0301);
    load_word(16'h0302);
    wait_hs(base + 2, 20, "realign_timeout");
    check_output("realign_last", 32'(hs_last[base + 1]), 32'd1);
    base = hs_count;
    apply_stimulus(1'b1, 1'b1);
    load_word(16'h0311);
    load_word(16'h0312);
    wait_hs(base + 2, 20, "half_burst_timeout");
    check_output("half_burst_last", 32'(hs_last[base + 1]), 32'd0);
    check_output("run_busy", 32'(busy), 32'd1);
    apply_stimulus(1'b0, 1'b1);
    for (int c = 0; (c < 10) && busy; c++) sample_point();
    check_output("stop_to_idle_busy", 32'(busy), 32'd0);
    base = hs_count;
    @(posedge clk);
    #2;
    load_word(16'h0321);
    load_word(16'h0322);
    n_rd = 0;
    for (int i = 0; i < 5; i++) begin
      sample_point();
      if (fifo_rd_en) n_rd++;
    end
    check_output("disabled_no_read", 32'(n_rd), 32'd0);
    apply_stimulus(1'b1, 1'b1);
    wait_hs(base + 2, 20, "resume_timeout");
    check_output("resume_last0", 32'(hs_last[base]), 32'd0);
    check_output("resume_last1", 32'(hs_last[base + 1]), 32'd1);
    check_output("resume_data1", 32'(hs_data[base + 1]), 32'h0322);

    $display("[TB] reset while the pipeline is full");
    base = hs_count;
    apply_stimulus(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) load_word(16'h0401 + 16'(i));
    wait_hs(base + 2, 20, "pre_reset_timeout");
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_output("reset_m_valid_async", 32'(m_valid), 32'd0);
    check_output("reset_m_data_async", 32'(m_data), 32'd0);
    repeat (2) sample_point();
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) load_word(16'h0411 + 16'(i));
    base = hs_count;
    wait_hs(base + 4, 40, "post_reset_timeout");
    for (int i = 0; i < 4; i++) begin
      check_output("post_reset_last", 32'(hs_last[base + i]), 32'(i == 3));
    end
    for (int c = 0; (c < 40) && !(fifo_empty && !m_valid && exp_q.size() == 0); c++) sample_point();
    check_output("post_reset_drained", 32'(fifo_empty && !m_valid), 32'd1);

    $display("[TB] randomized traffic");
    base    = hs_count;
    wr_base = wr_idx;
    for (int c = 0; c < 600; c++) begin
      @(posedge clk);
      #2;
      if (($urandom % 2) == 0) load_word(16'($urandom));
      m_ready = 1'($urandom % 2);
      enable  = (($urandom % 10) != 0);
    end
    apply_stimulus(1'b1, 1'b1);
    for (int c = 0; (c < 100) && !(fifo_empty && !m_valid && exp_q.size() == 0); c++) sample_point();
    check_output("rand_drained", 32'(exp_q.size()), 32'd0);
    check_output("rand_word_count", 32'(hs_count - base), 32'(wr_idx - wr_base));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
